// File: rtl/johnson_decoder.sv
// johnson_decoder: registered decoder/checker for Johnson-coded state.
// Converts each sampled code into a binary index and a one-hot vector,
// flags illegal codes, and keeps a saturating error count.
// Optional feature macro: JOHNSON_DECODER_SEQ_CHECK_EN
//   defined   -> lock FSM, prev register, mismatch tracking and seq_err built
//   undefined -> seq_err/locked tied to 0, err_count counts illegal codes only
module johnson_decoder #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDXW  = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     code,
  output logic                 out_valid,
  output logic [IDXW-1:0]      idx,
  output logic [2*WIDTH-1:0]   onehot,
  output logic                 illegal,
  output logic                 seq_err,
  output logic                 locked,
  output logic [7:0]           err_count
);

  localparam int unsigned NST = 2 * WIDTH;
  localparam int unsigned CNTW = 8;

  // Johnson code for state k: k LSBs set for k<=WIDTH, else (2*WIDTH-k) MSBs set.
  function automatic logic [WIDTH-1:0] johnson_pattern(input int unsigned k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k <= WIDTH) return ~(ones << k);
    else            return ones << (k - WIDTH);
  endfunction

  logic                 code_legal_c;
  logic [IDXW-1:0]      code_idx_c;
  logic [NST-1:0]       code_onehot_c;

  logic                 out_valid_q, out_valid_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [NST-1:0]       onehot_q, onehot_d;
  logic                 illegal_q, illegal_d;
  logic                 seq_err_q, seq_err_d;
  logic [CNTW-1:0]      err_count_q, err_count_d;

`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      prev_q, prev_d;
  logic                 mis_q, mis_d;
  logic [IDXW-1:0]      succ_c;
`endif

  // Match the incoming code against every member of the sequence.
  always_comb begin
    code_legal_c  = 1'b0;
    code_idx_c    = '0;
    code_onehot_c = '0;
    for (int unsigned k = 0; k < NST; k++) begin
      if (code == johnson_pattern(k)) begin
        code_legal_c = 1'b1;
        code_idx_c   = IDXW'(k);
      end
    end
    if (code_legal_c) code_onehot_c[code_idx_c] = 1'b1;
  end

`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
  // Expected next index after prev, wrapping from 2*WIDTH-1 to 0.
  always_comb begin
    succ_c = (prev_q == IDXW'(NST - 1)) ? '0 : prev_q + IDXW'(1);
  end
`endif

  // Next-state logic for result registers, lock FSM and error counter.
  always_comb begin
    out_valid_d = in_valid;
    illegal_d   = in_valid & ~code_legal_c;
    seq_err_d   = 1'b0;
    idx_d       = idx_q;
    onehot_d    = onehot_q;
    if (in_valid) begin
      idx_d    = code_idx_c;
      onehot_d = code_onehot_c;
    end

`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
    state_d = state_q;
    prev_d  = prev_q;
    mis_d   = mis_q;
    if (in_valid) begin
      if (!code_legal_c) begin
        state_d = ST_UNLOCKED;
        mis_d   = 1'b0;
      end else begin
        prev_d = code_idx_c;
        case (state_q)
          ST_UNLOCKED: begin
            state_d = ST_LOCKED;
            mis_d   = 1'b0;
          end
          ST_LOCKED: begin
            if (code_idx_c == succ_c) begin
              mis_d = 1'b0;
            end else begin
              seq_err_d = 1'b1;
              // A second consecutive mismatch drops lock.
              if (mis_q) begin
                state_d = ST_UNLOCKED;
                mis_d   = 1'b0;
              end else begin
                mis_d = 1'b1;
              end
            end
          end
          default: state_d = ST_UNLOCKED;
        endcase
      end
    end
`endif

    err_count_d = err_count_q;
    if ((illegal_d || seq_err_d) && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNTW'(1);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      onehot_q    <= '0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
      state_q     <= ST_UNLOCKED;
      prev_q      <= '0;
      mis_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      onehot_q    <= onehot_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
      state_q     <= state_d;
      prev_q      <= prev_d;
      mis_q       <= mis_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign onehot    = onehot_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;
`ifdef JOHNSON_DECODER_SEQ_CHECK_EN
  assign locked    = (state_q == ST_LOCKED);
`else
  assign locked    = 1'b0;
`endif

endmodule
